// File: rtl/qspi_cont_read_master.sv
// QSPI Quad I/O continuous-read initiator. Each request runs one framed read
// (address, mode, turnaround, data) and streams received bytes as single-cycle pulses.
module qspi_cont_read_master #(
    parameter logic [7:0] MODE_BYTE      = 8'hA0,
    parameter int         DUMMY_NIBBLES  = 4,
    parameter int         LEN_W          = 8,
    parameter int         CS_HIGH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             busy,
    output logic             spi_clk,
    output logic             spi_cs_n,
    output logic [3:0]       spi_data_out,
    output logic [3:0]       spi_data_oe,
    input  logic [3:0]       spi_data_in
);

    localparam int CNT_W = 8;
    localparam logic [LEN_W:0] ONE_BYTE = (LEN_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        GAP
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] nib_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [31:0]      shift_reg;
    logic [LEN_W:0]   byte_rem;
    logic [3:0]       hi_nib;
    logic             nib_lo;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Phase changes are only taken when spi_clk is high, i.e. on the edge that
    // drives it low, so outgoing nibbles stay stable across the following rise.
    always_comb begin
        // NOTE: next_state gets a default before the case so no latch is inferred.
        next_state = state;
        case (state)
            IDLE:  if (req_valid) next_state = START;
            START: next_state = ADDR;
            ADDR:  if (spi_clk && nib_cnt == CNT_W'(6)) next_state = MODE;
            MODE:  if (spi_clk && nib_cnt == CNT_W'(2))
                       next_state = (DUMMY_NIBBLES == 0) ? DATA : DUMMY;
            DUMMY: if (spi_clk && nib_cnt == CNT_W'(DUMMY_NIBBLES)) next_state = DATA;
            DATA:  if (spi_clk && byte_rem == '0) next_state = GAP;
            GAP:   if (gap_cnt == CNT_W'(CS_HIGH_CYCLES - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop
    // sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_clk      <= 1'b0;
            spi_cs_n     <= 1'b1;
            spi_data_out <= 4'h0;
            spi_data_oe  <= 4'h0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            rd_data      <= 8'h00;
            shift_reg    <= '0;
            byte_rem     <= '0;
            hi_nib       <= 4'h0;
            nib_lo       <= 1'b0;
            nib_cnt      <= '0;
            gap_cnt      <= '0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        shift_reg <= {req_addr, MODE_BYTE};
                        byte_rem  <= (req_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, req_len};
                    end
                end
                START: begin
                    spi_cs_n     <= 1'b0;
                    spi_data_oe  <= 4'hF;
                    spi_data_out <= shift_reg[31:28];
                    shift_reg    <= {shift_reg[27:0], 4'h0};
                    nib_cnt      <= '0;
                    gap_cnt      <= '0;
                    nib_lo       <= 1'b0;
                end
                ADDR, MODE, DUMMY, DATA: begin
                    spi_clk <= ~spi_clk;
                    if (!spi_clk) begin
                        nib_cnt <= nib_cnt + CNT_W'(1);
                        if (state == DATA) begin
                            nib_lo <= ~nib_lo;
                            if (!nib_lo) begin
                                hi_nib <= spi_data_in;
                            end else begin
                                rd_valid <= 1'b1;
                                rd_data  <= {hi_nib, spi_data_in};
                                rd_last  <= (byte_rem == ONE_BYTE);
                                byte_rem <= byte_rem - ONE_BYTE;
                            end
                        end
                    end else begin
                        if (next_state != state) nib_cnt <= '0;
                        if (state == ADDR || state == MODE) begin
                            if (next_state == DUMMY || next_state == DATA) begin
                                spi_data_oe  <= 4'h0;
                                spi_data_out <= 4'h0;
                            end else begin
                                spi_data_out <= shift_reg[31:28];
                                shift_reg    <= {shift_reg[27:0], 4'h0};
                            end
                        end
                        if (next_state == GAP) spi_cs_n <= 1'b1;
                    end
                end
                GAP: gap_cnt <= gap_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
